dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU load/store path (driven by
//  the control unit's wen/md decode) and a host/DMA loader port. Two-requester
//  arbiter with req/ack handshake, fixed-latency memory sequencing and registered
//  read data. The CPU stalls on its request until cpu_ack_out pulses.
// PARAMETERS
//  DATA_W       16  data bus width
//  ADDR_W       16  address bus width
//  WAIT_CYCLES   1  cycles mem_en_out is held per access (>=1; elaboration error if 0)
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       reset, asynchronous, active-low
//  cpu_req_in      in   1       CPU access request, level, held until ack
//  cpu_wen_in      in   1       CPU write enable, active-low (0 = write, 1 = read)
//  cpu_addr_in     in   ADDR_W  CPU address
//  cpu_wdata_in    in   DATA_W  CPU write data
//  cpu_rdata_out   out  DATA_W  CPU read data, valid with cpu_ack_out
//  cpu_ack_out     out  1       one-cycle completion pulse to CPU
//  host_req_in     in   1       host request, level, held until ack
//  host_wen_in     in   1       host write enable, active-low
//  host_addr_in    in   ADDR_W  host address
//  host_wdata_in   in   DATA_W  host write data
//  host_rdata_out  out  DATA_W  host read data, valid with host_ack_out
//  host_ack_out    out  1       one-cycle completion pulse to host
//  mem_en_out      out  1       memory enable
//  mem_wen_out     out  1       memory write enable, active-low
//  mem_addr_out    out  ADDR_W  memory address
//  mem_wdata_out   out  DATA_W  memory write data
//  mem_rdata_in    in   DATA_W  memory read data, valid the cycle after last mem_en cycle
//  grant_out       out  2       current owner: 00 none, 01 CPU, 10 host
// BEHAVIOUR
//  - Reset (async, any state): state IDLE, cnt 0, last_owner = host, all acks 0,
//    mem_en_out 0, mem_wen_out 1, mem_addr/wdata 0, rdata regs 0, grant_out 00.
//  - FSM IDLE -> ACCESS -> CAPTURE -> DONE -> IDLE, all outputs registered.
//  - IDLE: sample reqs; if any set, latch owner, addr, wdata, wen -> ACCESS.
//  - Tie (both reqs set in IDLE): round-robin, winner = requester not in last_owner.
//    First tie after reset goes to CPU. last_owner updated on each grant.
//  - ACCESS: mem_en_out 1, mem_addr/wdata/wen from latched request; stays
//    WAIT_CYCLES cycles (down-counter, width $clog2(WAIT_CYCLES+1)) -> CAPTURE.
//  - CAPTURE: mem_en_out 0, mem_wen_out 1; on read, owner's rdata reg <= mem_rdata_in.
//    Writes leave rdata regs unchanged. -> DONE.
//  - DONE: owner's ack_out = 1 for exactly one cycle -> IDLE. grant_out 00 in IDLE only.
//  - Latency: req high in IDLE cycle t -> ack in cycle t+WAIT_CYCLES+2; one IDLE
//    cycle minimum between transactions (next grant earliest t+WAIT_CYCLES+3).
//  - Requester must drop req in cycle after ack; a req still high in that IDLE
//    cycle is a new transaction.
//  - Req dropped before ack: transaction still completes, ack still pulses.
//  - Req inputs / fields changing during ACCESS: ignored (latched copy used).
//  - Non-owner rdata reg holds its last value; never two acks in the same cycle.
// CONFIGURATION
//  - DMEM_ARB_HOST_PRIO_EN defined: fixed priority, host wins every tie;
//    last_owner still tracked but unused for arbitration.
//  - Undefined (default): round-robin as above.
// TESTING
//  - Reset: rst_n low mid-ACCESS -> next cycle mem_en 0, mem_wen 1, acks 0, grant 00.
//  - CPU read, WAIT_CYCLES=1, addr 0x0010, mem returns 0xBEEF -> cpu_ack at t+3,
//    cpu_rdata_out 0xBEEF, host_ack 0.
//  - Host write addr 0x0004 data 0x1234 -> mem_wen 0 for 1 cycle with that addr/data,
//    host_ack at t+3, rdata regs unchanged.
//  - Both reqs held continuously, 4 txns -> grants CPU,host,CPU,host; with
//    DMEM_ARB_HOST_PRIO_EN -> host,host,host,host.
//  - WAIT_CYCLES=3 CPU read -> mem_en high exactly 3 cycles, ack at t+5.
//  - CPU drops req at t+1 -> access still performed, cpu_ack pulses at t+3, then IDLE.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU and host request ports, memory port and grant.
// slave = arbiter side, master = requesters/memory side.
interface dmem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              cpu_req_in;
    logic              cpu_wen_in;
    logic [ADDR_W-1:0] cpu_addr_in;
    logic [DATA_W-1:0] cpu_wdata_in;
    logic [DATA_W-1:0] cpu_rdata_out;
    logic              cpu_ack_out;
    logic              host_req_in;
    logic              host_wen_in;
    logic [ADDR_W-1:0] host_addr_in;
    logic [DATA_W-1:0] host_wdata_in;
    logic [DATA_W-1:0] host_rdata_out;
    logic              host_ack_out;
    logic              mem_en_out;
    logic              mem_wen_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_wdata_out;
    logic [DATA_W-1:0] mem_rdata_in;
    logic [1:0]        grant_out;

    modport slave (
        input  cpu_req_in, cpu_wen_in, cpu_addr_in, cpu_wdata_in,
        output cpu_rdata_out, cpu_ack_out,
        input  host_req_in, host_wen_in, host_addr_in, host_wdata_in,
        output host_rdata_out, host_ack_out,
        output mem_en_out, mem_wen_out, mem_addr_out, mem_wdata_out,
        input  mem_rdata_in,
        output grant_out
    );

    modport master (
        output cpu_req_in, cpu_wen_in, cpu_addr_in, cpu_wdata_in,
        input  cpu_rdata_out, cpu_ack_out,
        output host_req_in, host_wen_in, host_addr_in, host_wdata_in,
        input  host_rdata_out, host_ack_out,
        input  mem_en_out, mem_wen_out, mem_addr_out, mem_wdata_out,
        output mem_rdata_in,
        input  grant_out
    );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU/host arbiter for the single-port data memory; all outputs registered.
// Define DMEM_ARB_HOST_PRIO_EN for fixed host priority on ties (default: round-robin).
module dmem_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("dmem_arbiter: WAIT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_CAPTURE, ST_DONE} state_e;
    typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_CPU = 2'b01, OWN_HOST = 2'b10} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_host_q, last_host_d;
    logic              wen_q, wen_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              host_ack_q, host_ack_d;
    logic              tie_host;
    logic              grant_host;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            grant_q      <= OWN_NONE;
            cnt_q        <= '0;
            last_host_q  <= 1'b1;
            wen_q        <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_wen_q    <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            last_host_q  <= last_host_d;
            wen_q        <= wen_d;
            mem_en_q     <= mem_en_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            host_ack_q   <= host_ack_d;
        end
    end

    // mem_addr_q/mem_wdata_q double as the latched request fields.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        last_host_d = last_host_q;
        wen_d       = wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef DMEM_ARB_HOST_PRIO_EN
        tie_host    = 1'b1;
`else
        tie_host    = ~last_host_q;
`endif
        grant_host  = bus.host_req_in & (~bus.cpu_req_in | tie_host);
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req_in || bus.host_req_in) begin
                    state_d     = ST_ACCESS;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    owner_d     = grant_host ? OWN_HOST : OWN_CPU;
                    last_host_d = grant_host;
                    wen_d       = grant_host ? bus.host_wen_in   : bus.cpu_wen_in;
                    mem_addr_d  = grant_host ? bus.host_addr_in  : bus.cpu_addr_in;
                    mem_wdata_d = grant_host ? bus.host_wdata_in : bus.cpu_wdata_in;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en_d     = (state_d == ST_ACCESS);
        mem_wen_d    = (state_d == ST_ACCESS) ? wen_d : 1'b1;
        grant_d      = (state_d == ST_IDLE) ? OWN_NONE : owner_d;
        cpu_ack_d    = (state_q == ST_CAPTURE) && (owner_q == OWN_CPU);
        host_ack_d   = (state_q == ST_CAPTURE) && (owner_q == OWN_HOST);
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        if ((state_q == ST_CAPTURE) && wen_q) begin
            if (owner_q == OWN_CPU) begin
                cpu_rdata_d = bus.mem_rdata_in;
            end else if (owner_q == OWN_HOST) begin
                host_rdata_d = bus.mem_rdata_in;
            end
        end
    end

    assign bus.mem_en_out     = mem_en_q;
    assign bus.mem_wen_out    = mem_wen_q;
    assign bus.mem_addr_out   = mem_addr_q;
    assign bus.mem_wdata_out  = mem_wdata_q;
    assign bus.cpu_rdata_out  = cpu_rdata_q;
    assign bus.host_rdata_out = host_rdata_q;
    assign bus.cpu_ack_out    = cpu_ack_q;
    assign bus.host_ack_out   = host_ack_q;
    assign bus.grant_out      = grant_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table on a WAIT_CYCLES=1 instance,
// plus reset, continuous-tie and WAIT_CYCLES=3 sequences.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();
    dmem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus3 ();

    dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem1[i] <= '0;
            mem1[8'h10] <= 16'hBEEF;
            mem1[8'h20] <= 16'hCAFE;
            bus.mem_rdata_in <= '0;
        end else if (bus.mem_en_out) begin
            if (!bus.mem_wen_out) mem1[bus.mem_addr_out[7:0]] <= bus.mem_wdata_out;
            else bus.mem_rdata_in <= mem1[bus.mem_addr_out[7:0]];
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem3[i] <= '0;
            mem3[8'h10] <= 16'hBEEF;
            bus3.mem_rdata_in <= '0;
        end else if (bus3.mem_en_out) begin
            if (!bus3.mem_wen_out) mem3[bus3.mem_addr_out[7:0]] <= bus3.mem_wdata_out;
            else bus3.mem_rdata_in <= mem3[bus3.mem_addr_out[7:0]];
        end
    end

    typedef struct {
        logic        cpu_req;
        logic        cpu_wen;
        logic [15:0] cpu_addr;
        logic [15:0] cpu_wdata;
        logic        host_req;
        logic        host_wen;
        logic [15:0] host_addr;
        logic [15:0] host_wdata;
        logic [1:0]  exp_grant;
        logic        exp_wen;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [15:0] exp_cpu_rdata;
        logic [15:0] exp_host_rdata;
    } vec_t;

    vec_t vecs [6];
    logic [1:0] tie_exp [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        bus.cpu_req_in    = 1'b0;
        bus.host_req_in   = 1'b0;
        bus.cpu_addr_in   = 16'hFFFF;
        bus.host_addr_in  = 16'hFFFF;
        bus.cpu_wen_in    = 1'b0;
        bus.host_wen_in   = 1'b0;
    endtask

    initial begin
        int waited;
        int prev_cyc;
        logic [5:0] en_seen;
        logic [5:0] ack_seen;
        logic host_ack_seen;

        vecs[0] = '{1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000,
                    2'b01, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'h1234,
                    2'b10, 1'b0, 16'h0004, 16'h1234, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h9999,
                    2'b10, 1'b1, 16'h0004, 16'h9999, 16'hBEEF, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 16'h0020, 16'h5555, 1'b0, 1'b1, 16'h0000, 16'h0000,
                    2'b01, 1'b0, 16'h0020, 16'h5555, 16'hBEEF, 16'h1234};
        vecs[4] = '{1'b1, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000,
                    2'b01, 1'b1, 16'h0020, 16'h0000, 16'h5555, 16'h1234};
        // Tie after a CPU grant: host wins in either arbitration mode.
        vecs[5] = '{1'b1, 1'b1, 16'h0010, 16'h7777, 1'b1, 1'b1, 16'h0020, 16'h0BAD,
                    2'b10, 1'b1, 16'h0020, 16'h0BAD, 16'h5555, 16'h5555};
`ifdef DMEM_ARB_HOST_PRIO_EN
        tie_exp = '{2'b10, 2'b10, 2'b10, 2'b10};
`else
        tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        rst_n = 1'b0;
        bus.cpu_req_in = 1'b0;  bus.cpu_wen_in = 1'b1;  bus.cpu_addr_in = '0;  bus.cpu_wdata_in = '0;
        bus.host_req_in = 1'b0; bus.host_wen_in = 1'b1; bus.host_addr_in = '0; bus.host_wdata_in = '0;
        bus3.cpu_req_in = 1'b0;  bus3.cpu_wen_in = 1'b1;  bus3.cpu_addr_in = '0;  bus3.cpu_wdata_in = '0;
        bus3.host_req_in = 1'b0; bus3.host_wen_in = 1'b1; bus3.host_addr_in = '0; bus3.host_wdata_in = '0;
        @(negedge clk);
        @(negedge clk);

        check("rst_grant", bus.grant_out, 2'b00);
        check("rst_mem_en", bus.mem_en_out, 1'b0);
        check("rst_mem_wen", bus.mem_wen_out, 1'b1);
        check("rst_mem_addr", bus.mem_addr_out, 16'h0000);
        check("rst_mem_wdata", bus.mem_wdata_out, 16'h0000);
        check("rst_acks", {bus.host_ack_out, bus.cpu_ack_out}, 2'b00);
        check("rst_rdata", {bus.cpu_rdata_out, bus.host_rdata_out}, 32'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            bus.cpu_req_in    = vecs[v].cpu_req;
            bus.cpu_wen_in    = vecs[v].cpu_wen;
            bus.cpu_addr_in   = vecs[v].cpu_addr;
            bus.cpu_wdata_in  = vecs[v].cpu_wdata;
            bus.host_req_in   = vecs[v].host_req;
            bus.host_wen_in   = vecs[v].host_wen;
            bus.host_addr_in  = vecs[v].host_addr;
            bus.host_wdata_in = vecs[v].host_wdata;
            step();
            check($sformatf("v%0d_grant", v), bus.grant_out, vecs[v].exp_grant);
            check($sformatf("v%0d_mem_en", v), bus.mem_en_out, 1'b1);
            check($sformatf("v%0d_mem_wen", v), bus.mem_wen_out, vecs[v].exp_wen);
            check($sformatf("v%0d_mem_addr", v), bus.mem_addr_out, vecs[v].exp_addr);
            check($sformatf("v%0d_mem_wdata", v), bus.mem_wdata_out, vecs[v].exp_wdata);
            drop_reqs();
            step();
            check($sformatf("v%0d_cap_en_wen", v), {bus.mem_en_out, bus.mem_wen_out}, 2'b01);
            check($sformatf("v%0d_cap_acks", v), {bus.host_ack_out, bus.cpu_ack_out}, 2'b00);
            step();
            check($sformatf("v%0d_ack", v), {bus.host_ack_out, bus.cpu_ack_out}, vecs[v].exp_grant);
            check($sformatf("v%0d_cpu_rdata", v), bus.cpu_rdata_out, vecs[v].exp_cpu_rdata);
            check($sformatf("v%0d_host_rdata", v), bus.host_rdata_out, vecs[v].exp_host_rdata);
            step();
            check($sformatf("v%0d_idle", v), {bus.grant_out, bus.host_ack_out, bus.cpu_ack_out}, 4'b0000);
        end

        // Asynchronous reset while in ACCESS.
        @(negedge clk);
        bus.cpu_req_in = 1'b1; bus.cpu_wen_in = 1'b1; bus.cpu_addr_in = 16'h0010;
        step();
        check("mid_access_en", bus.mem_en_out, 1'b1);
        rst_n = 1'b0;
        bus.cpu_req_in = 1'b0;
        #1;
        check("mid_rst_async", {bus.mem_en_out, bus.mem_wen_out, bus.host_ack_out, bus.cpu_ack_out, bus.grant_out}, 6'b010000);
        check("mid_rst_rdata", {bus.cpu_rdata_out, bus.host_rdata_out}, 32'h0);
        step();
        check("mid_rst_next", {bus.mem_en_out, bus.mem_wen_out, bus.host_ack_out, bus.cpu_ack_out, bus.grant_out}, 6'b010000);
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters held continuously for four transactions.
        @(negedge clk);
        bus.cpu_req_in = 1'b1;  bus.cpu_wen_in = 1'b1;  bus.cpu_addr_in = 16'h0010;
        bus.host_req_in = 1'b1; bus.host_wen_in = 1'b1; bus.host_addr_in = 16'h0020;
        prev_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (bus.grant_out == 2'b00 && waited < 12) begin
                step();
                waited++;
            end
            check($sformatf("tie%0d_grant", k), bus.grant_out, tie_exp[k]);
            if (k > 0) check($sformatf("tie%0d_gap", k), cyc - prev_cyc, 4);
            prev_cyc = cyc;
            step();
            step();
            check($sformatf("tie%0d_ack", k), {bus.host_ack_out, bus.cpu_ack_out}, tie_exp[k]);
            if (tie_exp[k] == 2'b01) check($sformatf("tie%0d_cpu_rdata", k), bus.cpu_rdata_out, 16'hBEEF);
            else check($sformatf("tie%0d_host_rdata", k), bus.host_rdata_out, 16'hCAFE);
            if (k == 3) begin
                bus.cpu_req_in = 1'b0;
                bus.host_req_in = 1'b0;
            end
            step();
            check($sformatf("tie%0d_idle", k), bus.grant_out, 2'b00);
        end
        step();
        check("tie_no_extra", {bus.grant_out, bus.mem_en_out}, 3'b000);

        // WAIT_CYCLES=3: enable held three cycles, ack at t+5, req dropped at t+1.
        @(negedge clk);
        bus3.cpu_req_in = 1'b1; bus3.cpu_wen_in = 1'b1; bus3.cpu_addr_in = 16'h0010;
        en_seen = '0;
        ack_seen = '0;
        host_ack_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) bus3.cpu_req_in = 1'b0;
            en_seen[c] = bus3.mem_en_out;
            ack_seen[c] = bus3.cpu_ack_out;
            host_ack_seen = host_ack_seen | bus3.host_ack_out;
        end
        check("w3_mem_en_cycles", en_seen, 6'b000111);
        check("w3_ack_cycle", ack_seen, 6'b010000);
        check("w3_host_ack", host_ack_seen, 1'b0);
        check("w3_cpu_rdata", bus3.cpu_rdata_out, 16'hBEEF);
        check("w3_idle", bus3.grant_out, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
